// File: rtl/csea_pipe.sv
// rtl/csea_pipe.sv - pipelined carry-select adder with valid/ready handshake
// Define CSEA_SAT_EN to saturate sum on signed overflow (ovf/cout stay raw).
module csea_pipe #(
  parameter int WIDTH  = 16,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int W   = WIDTH / STAGES;  // result bits resolved per stage
  localparam int NBS = W / BLK;         // carry-select blocks per stage

  logic stall;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int RI = WIDTH - s * W;  // operand bits still unprocessed at stage input

    logic [RI-1:0]        a_i;
    logic [RI-1:0]        b_i;
    logic                 c_i;
    logic                 v_i;
    logic                 as_i;
    logic                 bs_i;
    logic [NBS:0]         cc;
    logic [W-1:0]         blk_sum;
    logic [(s+1)*W-1:0]   sum_n;

    logic [(s+1)*W-1:0]   sum_q;
    logic                 c_q;
    logic                 v_q;
    logic                 as_q;
    logic                 bs_q;

    if (s == 0) begin : g_in
      assign a_i   = a;
      assign b_i   = b;
      assign c_i   = cin;
      assign v_i   = in_valid;
      assign as_i  = a[WIDTH-1];
      assign bs_i  = b[WIDTH-1];
      assign sum_n = blk_sum;
    end else begin : g_chain
      assign a_i   = g_stage[s-1].g_rem.a_q;
      assign b_i   = g_stage[s-1].g_rem.b_q;
      assign c_i   = g_stage[s-1].c_q;
      assign v_i   = g_stage[s-1].v_q;
      assign as_i  = g_stage[s-1].as_q;
      assign bs_i  = g_stage[s-1].bs_q;
      assign sum_n = {blk_sum, g_stage[s-1].sum_q};
    end

    assign cc[0] = c_i;

    // Both block sums are ready before the carry arrives; the carry only steers a mux.
    for (genvar j = 0; j < NBS; j++) begin : g_blk
      logic [BLK:0] r0;
      logic [BLK:0] r1;
      assign r0 = {1'b0, a_i[j*BLK +: BLK]} + {1'b0, b_i[j*BLK +: BLK]};
      assign r1 = {1'b0, a_i[j*BLK +: BLK]} + {1'b0, b_i[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
      assign blk_sum[j*BLK +: BLK] = cc[j] ? r1[BLK-1:0] : r0[BLK-1:0];
      assign cc[j+1]               = cc[j] ? r1[BLK]     : r0[BLK];
    end

    // Data registers load only for valid slots so the output keeps the last result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        as_q  <= 1'b0;
        bs_q  <= 1'b0;
        sum_q <= '0;
      end else if (!stall) begin
        v_q <= v_i;
        if (v_i) begin
          c_q   <= cc[NBS];
          as_q  <= as_i;
          bs_q  <= bs_i;
          sum_q <= sum_n;
        end
      end
    end

    if (s < STAGES - 1) begin : g_rem
      logic [RI-W-1:0] a_q;
      logic [RI-W-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && v_i) begin
          a_q <= a_i[RI-1:W];
          b_q <= b_i[RI-1:W];
        end
      end
    end
  end

  logic [WIDTH-1:0] raw;
  logic             as_l;
  logic             bs_l;

  assign out_valid = g_stage[STAGES-1].v_q;
  assign raw       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign as_l      = g_stage[STAGES-1].as_q;
  assign bs_l      = g_stage[STAGES-1].bs_q;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign ovf       = (as_l == bs_l) && (raw[WIDTH-1] != as_l);

`ifdef CSEA_SAT_EN
  assign sum = !ovf ? raw :
               as_l ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum = raw;
`endif

endmodule
